// File: rtl/tcp_test_pkg.sv
// -----------------------------------------------------------------------------
// tcp_test_pkg
// Shared constants and types for the TCP test-data TX path (CLK156M domain).
//   BYTES_PER_WORD : bytes carried by one 64-bit data word
//   BCNT_W         : width of a byte-count field (holds 0..15)
//   state_e        : packer state, IDLE (no residue) / PACK (residue held)
// -----------------------------------------------------------------------------
package tcp_test_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int BCNT_W         = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_e;

endpackage : tcp_test_pkg

// File: rtl/tcp_byte_merge.sv
// -----------------------------------------------------------------------------
// tcp_byte_merge
// Purely combinational merge of the held residue with the incoming word.
// Byte 0 of the result is the oldest residue byte; the incoming bytes follow
// directly after the last residue byte. Bytes beyond the total are zero, so a
// flush word comes out zero-padded for free.
// Ports:
//   res_i    : residue bytes 0..6 (byte k at [8k+7:8k])
//   rcnt_i   : number of valid residue bytes (0..7)
//   in_d_i   : incoming data word
//   in_b_i   : valid incoming bytes, already clamped to 0..8
//   merged_o : 15-byte merged vector
//   total_o  : rcnt_i + in_b_i (0..15)
// -----------------------------------------------------------------------------
module tcp_byte_merge
  import tcp_test_pkg::*;
(
  input  logic [8*(BYTES_PER_WORD-1)-1:0] res_i,
  input  logic [2:0]                      rcnt_i,
  input  logic [8*BYTES_PER_WORD-1:0]     in_d_i,
  input  logic [BCNT_W-1:0]               in_b_i,
  output logic [8*(2*BYTES_PER_WORD-1)-1:0] merged_o,
  output logic [BCNT_W-1:0]               total_o
);

  logic [8*(BYTES_PER_WORD-1)-1:0] res_m;
  logic [8*BYTES_PER_WORD-1:0]     din_m;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    res_m = '0;
    din_m = '0;
    // Mask off stale bytes so nothing beyond the valid counts leaks out.
    for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
      if (3'(k) < rcnt_i) res_m[8*k +: 8] = res_i[8*k +: 8];
    end
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (BCNT_W'(k) < in_b_i) din_m[8*k +: 8] = in_d_i[8*k +: 8];
    end
    merged_o = ({56'b0, din_m} << {rcnt_i, 3'b000}) | {64'b0, res_m};
    total_o  = {1'b0, rcnt_i} + in_b_i;
  end

endmodule : tcp_byte_merge

// File: rtl/tcp_tx_packer.sv
// -----------------------------------------------------------------------------
// tcp_tx_packer
// Repacks variable-width (0..8 byte) words from the test data generator into
// dense 8-byte words for SiTCPXG. Partial residue is emitted on FLUSH or after
// FLUSH_TIMEOUT idle cycles. Output has one cycle of latency.
// Ports:
//   CLK156M     : 156.25 MHz clock
//   RSTs_N      : synchronous reset, active-low
//   ESTABLISHED : connection up; when low, input is discarded and residue dropped
//   IN_D / IN_B : input data and valid byte count (values above 8 act as 8)
//   IN_AFULL    : registered back-pressure upstream
//   FLUSH       : single-cycle request to emit the residue
//   OUT_D/OUT_B : packed data and its byte count (0, 8, or 1..7 on a flush)
//   OUT_AFULL   : almost-full from SiTCPXG
//   TX_BYTES    : bytes emitted since reset, wraps modulo 2^64
//   ERR_B       : sticky, set when IN_B > 8 is seen
// -----------------------------------------------------------------------------
module tcp_tx_packer
  import tcp_test_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 64,
  parameter int TOUT_W        = 16
) (
  input  logic                  CLK156M,
  input  logic                  RSTs_N,
  input  logic                  ESTABLISHED,
  input  logic [63:0]           IN_D,
  input  logic [BCNT_W-1:0]     IN_B,
  output logic                  IN_AFULL,
  input  logic                  FLUSH,
  output logic [63:0]           OUT_D,
  output logic [BCNT_W-1:0]     OUT_B,
  input  logic                  OUT_AFULL,
  output logic [63:0]           TX_BYTES,
  output logic                  ERR_B
);

  localparam logic [BCNT_W-1:0] WORD_B = BCNT_W'(BYTES_PER_WORD);
  localparam logic [TOUT_W-1:0] TOUT   = TOUT_W'(FLUSH_TIMEOUT);

  logic [55:0]        res_q,  res_d;
  logic [2:0]         rcnt_q, rcnt_d;
  logic               pend_q, pend_d;
  logic [TOUT_W-1:0]  idle_q, idle_d;
  state_e             state_q, state_d;
  logic [63:0]        out_d_q, out_d_d;
  logic [BCNT_W-1:0]  out_b_q, out_b_d;
  logic               afull_q;
  logic [63:0]        tx_q;
  logic               err_q;

  logic [BCNT_W-1:0]  in_b_c;
  logic [119:0]       merged;
  logic [BCNT_W-1:0]  total;
  logic               flush_c;

  assign in_b_c = (IN_B > WORD_B) ? WORD_B : IN_B;

  tcp_byte_merge u_merge (
    .res_i    (res_q),
    .rcnt_i   (rcnt_q),
    .in_d_i   (IN_D),
    .in_b_i   (in_b_c),
    .merged_o (merged),
    .total_o  (total)
  );

  // A pending spill remainder keeps the flush alive for one more cycle.
  assign flush_c = FLUSH | pend_q | ((state_q == PACK) && (idle_q == TOUT));

  always_comb begin
    res_d   = '0;
    rcnt_d  = '0;
    pend_d  = 1'b0;
    out_d_d = '0;
    out_b_d = '0;
    if (ESTABLISHED) begin
      // total[2:0] is both the residue for total < 8 and total-8 otherwise.
      rcnt_d = total[2:0];
      if (total >= WORD_B) begin
        out_d_d = merged[63:0];
        out_b_d = WORD_B;
        res_d   = merged[119:64];
        pend_d  = flush_c && (total != WORD_B);
      end else if (flush_c && (total != '0)) begin
        out_d_d = merged[63:0];
        out_b_d = total;
        rcnt_d  = '0;
      end else begin
        res_d = merged[55:0];
      end
    end

    state_d = (rcnt_d != '0) ? PACK : IDLE;

    // Idle run only counts while residue is held and nothing arrives.
    idle_d = '0;
    if ((state_d == PACK) && (state_q == PACK) && (in_b_c == '0)) begin
      idle_d = (idle_q == TOUT) ? idle_q : idle_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK156M) begin
    if (!RSTs_N) begin
      res_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
      state_q <= IDLE;
      out_d_q <= '0;
      out_b_q <= '0;
      afull_q <= 1'b1;
      tx_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
      state_q <= state_d;
      out_d_q <= out_d_d;
      out_b_q <= out_b_d;
      afull_q <= OUT_AFULL | ~ESTABLISHED;
      tx_q    <= tx_q + 64'(out_b_d);
      err_q   <= err_q | (ESTABLISHED && (IN_B > WORD_B));
    end
  end

  assign IN_AFULL = afull_q;
  assign OUT_D    = out_d_q;
  assign OUT_B    = out_b_q;
  assign TX_BYTES = tx_q;
  assign ERR_B    = err_q;

endmodule : tcp_tx_packer

// File: tb/tb_tcp_tx_packer.sv
// -----------------------------------------------------------------------------
// tb_tcp_tx_packer
// Randomised plus directed stimulus against a byte-queue reference model.
// Expected words are queued with the cycle they must appear; a negedge monitor
// pops and compares whenever OUT_B is nonzero and checks status every cycle.
// -----------------------------------------------------------------------------
module tb_tcp_tx_packer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        est = 1'b0;
  logic [63:0] in_d = '0;
  logic [3:0]  in_b = '0;
  logic        flush = 1'b0;
  logic        out_afull = 1'b0;
  logic        in_afull;
  logic [63:0] out_d;
  logic [3:0]  out_b;
  logic [63:0] tx_bytes;
  logic        err_b;

  tcp_tx_packer #(.FLUSH_TIMEOUT(TO), .TOUT_W(16)) dut (
    .CLK156M     (clk),
    .RSTs_N      (rst_n),
    .ESTABLISHED (est),
    .IN_D        (in_d),
    .IN_B        (in_b),
    .IN_AFULL    (in_afull),
    .FLUSH       (flush),
    .OUT_D       (out_d),
    .OUT_B       (out_b),
    .OUT_AFULL   (out_afull),
    .TX_BYTES    (tx_bytes),
    .ERR_B       (err_b)
  );

  always #3 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  b;
    logic [63:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  bit          m_pend;
  int          m_idle;
  logic [63:0] m_tx, exp_tx;
  bit          m_err, exp_err;
  bit          m_afull, exp_afull;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference model: bytes are a FIFO; a word leaves when 8 bytes are present
  // or a flush drains whatever is there.
  task automatic model(input bit rst, input bit e, input logic [63:0] d,
                       input logic [3:0] b, input bit f, input bit af);
    int   nb;
    bit   had;
    bit   fl;
    exp_t x;
    if (rst) begin
      mq.delete(); m_pend = 0; m_idle = 0; m_tx = '0; m_err = 0; m_afull = 1;
      return;
    end
    m_afull = af | ~e;
    if (!e) begin
      mq.delete(); m_pend = 0; m_idle = 0;
      return;
    end
    if (b > 8) m_err = 1;
    nb  = (b > 8) ? 8 : int'(b);
    had = (mq.size() != 0);
    fl  = f || m_pend || (had && m_idle == TO);
    for (int i = 0; i < nb; i++) mq.push_back(d[8*i +: 8]);
    m_pend = 0;
    x.d = '0;
    x.b = '0;
    if (mq.size() >= 8) begin
      for (int i = 0; i < 8; i++) x.d[8*i +: 8] = mq.pop_front();
      x.b = 4'd8;
      m_pend = fl && (mq.size() != 0);
    end else if (fl && mq.size() != 0) begin
      x.b = 4'(mq.size());
      for (int i = 0; i < int'(x.b); i++) x.d[8*i +: 8] = mq.pop_front();
    end
    if (x.b != 0) begin
      x.cyc = cyc + 1;
      m_tx  = m_tx + 64'(x.b);
      sb.push_back(x);
    end
    if (mq.size() != 0 && had && nb == 0) m_idle = (m_idle + 1 > TO) ? TO : m_idle + 1;
    else m_idle = 0;
  endtask

  task automatic drive(input bit rst, input bit e, input logic [63:0] d,
                       input logic [3:0] b, input bit f, input bit af);
    rst_n = ~rst; est = e; in_d = d; in_b = b; flush = f; out_afull = af;
    model(rst, e, d, b, f, af);
    @(posedge clk);
    #1;
    exp_tx = m_tx; exp_err = m_err; exp_afull = m_afull;
    mon_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, {$urandom, $urandom}, 4'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      check("in_afull", in_afull == exp_afull, 64'(in_afull), 64'(exp_afull));
      check("err_b", err_b == exp_err, 64'(err_b), 64'(exp_err));
      check("tx_bytes", tx_bytes == exp_tx, tx_bytes, exp_tx);
      if (out_b != 0) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 1'b0, 64'(out_b), 64'd0);
        end else begin
          x = sb.pop_front();
          check("word_cycle", cyc == x.cyc, 64'(cyc), 64'(x.cyc));
          check("word_b", out_b == x.b, 64'(out_b), 64'(x.b));
          check("word_d", out_d == x.d, out_d, x.d);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        x = sb.pop_front();
        check("missing_word", 1'b0, 64'(cyc), 64'(x.cyc));
      end
    end
  end

  initial begin
    // Reset state
    drive(1, 0, '0, 4'd0, 0, 0);
    drive(1, 0, '0, 4'd0, 0, 0);
    check("reset_out_b", out_b == 0, 64'(out_b), 64'd0);
    check("reset_out_d", out_d == 0, out_d, 64'd0);
    idle(2);

    // Aligned stream: ten full words pass straight through
    for (int i = 0; i < 10; i++) drive(0, 1, {$urandom, $urandom}, 4'd8, 0, 0);
    idle(1);
    check("aligned_tx", tx_bytes == 64'd80, tx_bytes, 64'd80);

    // Odd packing 3+3+3, then a flush exposes the single leftover byte 0x09
    drive(0, 1, 64'hDEAD_BEEF_AA03_0201, 4'd3, 0, 0);
    drive(0, 1, 64'h1122_3344_5506_0504, 4'd3, 0, 0);
    drive(0, 1, 64'hFFFF_FFFF_FF09_0807, 4'd3, 0, 0);
    drive(0, 1, 64'h0123_4567_89AB_CDEF, 4'd0, 1, 0);
    idle(1);

    // Timeout flush of a 5-byte residue with no further input
    drive(0, 1, 64'hCAFE_F00D_1234_5678, 4'd5, 0, 0);
    idle(8);

    // FLUSH with spill: 6 held, 7 more plus FLUSH -> 8 then 5
    drive(0, 1, {$urandom, $urandom}, 4'd6, 0, 0);
    drive(0, 1, {$urandom, $urandom}, 4'd7, 1, 0);
    idle(3);

    // Connection drop with residue, oversize count while down, then recovery
    drive(0, 1, {$urandom, $urandom}, 4'd3, 0, 0);
    drive(0, 0, {$urandom, $urandom}, 4'd12, 0, 0);
    drive(0, 0, {$urandom, $urandom}, 4'd12, 1, 0);
    drive(0, 1, {$urandom, $urandom}, 4'd0, 1, 0);
    drive(0, 1, {$urandom, $urandom}, 4'd12, 0, 1);
    drive(0, 0, '0, 4'd0, 0, 0);
    drive(0, 1, '0, 4'd0, 0, 0);
    check("err_sticky", err_b == 1'b1, 64'(err_b), 64'd1);

    // Reset mid-stream with 4 bytes held
    drive(0, 1, {$urandom, $urandom}, 4'd4, 0, 0);
    drive(1, 1, {$urandom, $urandom}, 4'd8, 0, 0);
    check("midrst_out_b", out_b == 0, 64'(out_b), 64'd0);
    check("midrst_tx", tx_bytes == 0, tx_bytes, 64'd0);
    check("midrst_err", err_b == 0, 64'(err_b), 64'd0);
    check("midrst_afull", in_afull == 1, 64'(in_afull), 64'd1);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [3:0]  b;
      r = $urandom_range(0, 9);
      b = (r < 3) ? 4'd0 : (r == 9) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
      drive(0, $urandom_range(0, 19) != 0, {$urandom, $urandom}, b,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 30) == 0) idle(6);
    end

    // Drain
    drive(0, 1, '0, 4'd0, 1, 0);
    idle(4);
    check("sb_empty", sb.size() == 0, 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_tcp_tx_packer
